// File: rtl/ps2_pkg.sv
// Shared types, PS/2 protocol constants and small helpers for the keyboard
// front end and held-key tracker.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_entry_t;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_BAT  = 8'hAA;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  // PS/2 uses odd parity over the data byte plus the parity bit.
  function automatic logic odd_weight(input logic [8:0] bits);
    return ^bits;
  endfunction

  // True for bytes that describe a key; prefixes and keyboard status codes are not keys.
  function automatic logic is_key_code(input logic [7:0] code);
    logic key;
    case (code)
      PS2_EXT, PS2_BRK, PS2_BAT, PS2_ERR0, PS2_ERR1: key = 1'b0;
      default:                                       key = 1'b1;
    endcase
    return key;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame receiver: synchronizers, clock
// glitch filter, start/data/parity/stop FSM and inactivity timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       psClk,
  input  logic       psData,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_meta, clk_sync;
  logic          data_meta, data_sync;
  logic          filt_clk, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] tcount;

  frame_state_t  state, next_state;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          par_bit;

  logic          fall;
  logic          timeout;
  logic          stop_fall;
  logic          good;

  // Two-flop synchronizers; both lines idle high.
  always_ff @(posedge Clk) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= psClk;
      clk_sync  <= clk_meta;
      data_meta <= psData;
      data_sync <= data_meta;
    end
  end

  // Filtered clock follows the synchronized clock only after a stable run of FILTER_LEN samples.
  always_ff @(posedge Clk) begin
    if (reset) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_sync == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall = filt_prev & ~filt_clk;

  // Frame state register.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a falling edge always wins over an expiring timeout.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (fall && !data_sync) next_state = DATA;
        else                    next_state = IDLE;
      end
      DATA: begin
        if (timeout)                      next_state = IDLE;
        else if (fall && bit_cnt == 3'd7) next_state = PARITY;
        else                              next_state = DATA;
      end
      PARITY: begin
        if (timeout)   next_state = IDLE;
        else if (fall) next_state = STOP;
        else           next_state = PARITY;
      end
      STOP: begin
        if (timeout || fall) next_state = IDLE;
        else                 next_state = STOP;
      end
      default: next_state = IDLE;
    endcase
  end

  // Frame qualification terms.
  always_comb begin
    timeout   = (state != IDLE) && !fall && (tcount == TW'(TIMEOUT_CYCLES - 1));
    stop_fall = (state == STOP) && fall;
    good      = data_sync && odd_weight({par_bit, shift});
  end

  // Shift register, bit counter, parity capture, timeout counter and result strobes.
  always_ff @(posedge Clk) begin
    if (reset) begin
      shift      <= 8'h00;
      bit_cnt    <= 3'd0;
      par_bit    <= 1'b0;
      tcount     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_byte    <= 8'h00;
    end else begin
      if (state == DATA && fall) begin
        shift   <= {data_sync, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end else if (state == IDLE) begin
        bit_cnt <= 3'd0;
      end else begin
        bit_cnt <= bit_cnt;
      end

      if (state == PARITY && fall) par_bit <= data_sync;
      else                         par_bit <= par_bit;

      if (state == IDLE || fall)                   tcount <= '0;
      else if (tcount != TW'(TIMEOUT_CYCLES - 1)) tcount <= tcount + TW'(1);
      else                                         tcount <= tcount;

      byte_valid <= stop_fall && good;
      frame_err  <= stop_fall && !good;
      if (stop_fall) rx_byte <= shift;
      else           rx_byte <= rx_byte;
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: E0/F0 prefix decode and a recency-ordered table of
// held keys (slot 0 = most recently pressed).
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                             Clk,
  input  logic                             reset,
  input  logic                             psClk,
  input  logic                             psData,
  output logic [NUM_SLOTS*8-1:0]           key_code,
  output logic [NUM_SLOTS-1:0]             key_ext,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   keyCount,
  output logic                             press,
  output logic                             keyFull,
  output logic                             scan_valid,
  output logic [7:0]                       scan_code,
  output logic                             scan_ext,
  output logic                             scan_break,
  output logic                             frame_err
);

  localparam int              CW   = $clog2(NUM_SLOTS + 1);
  localparam logic [CW-1:0]   FULL = CW'(NUM_SLOTS);

  logic                 rx_valid;
  logic [7:0]           rx_byte;
  logic                 rx_err;

  logic                 ext_pend, brk_pend;
  key_entry_t           slots     [NUM_SLOTS];
  key_entry_t           nxt_slots [NUM_SLOTS];
  logic [CW-1:0]        nxt_count;
  logic [NUM_SLOTS-1:0] hit_vec;
  logic                 hit;
  int                   hit_idx;
  logic                 is_event;
  key_entry_t           ev;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .Clk        (Clk),
    .reset      (reset),
    .psClk      (psClk),
    .psData     (psData),
    .byte_valid (rx_valid),
    .rx_byte    (rx_byte),
    .frame_err  (rx_err)
  );

  // Event qualification and lookup of the (code, ext) pair among occupied slots.
  always_comb begin
    ev       = '{ext: ext_pend, code: rx_byte};
    is_event = rx_valid && is_key_code(rx_byte);
    hit_idx  = 0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      hit_vec[i] = (CW'(i) < keyCount) && (slots[i] == ev);
      hit_idx    = hit_vec[i] ? i : hit_idx;
    end
    hit = |hit_vec;
  end

  // Next table: insert a new make at slot 0, close the gap left by a matching break.
  always_comb begin
    nxt_slots = slots;
    nxt_count = keyCount;
    if (is_event && !brk_pend && !hit) begin
      for (int i = 1; i < NUM_SLOTS; i++) nxt_slots[i] = slots[i-1];
      nxt_slots[0] = ev;
      nxt_count    = (keyCount == FULL) ? keyCount : keyCount + CW'(1);
    end else if (is_event && brk_pend && hit) begin
      for (int i = 0; i < NUM_SLOTS - 1; i++) begin
        nxt_slots[i] = (i >= hit_idx) ? slots[i+1] : slots[i];
      end
      nxt_slots[NUM_SLOTS-1] = '0;
      nxt_count              = keyCount - CW'(1);
    end else begin
      nxt_slots = slots;
      nxt_count = keyCount;
    end
  end

  // Table, status flags, event strobe and prefix state.
  always_ff @(posedge Clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      keyCount   <= '0;
      press      <= 1'b0;
      keyFull    <= 1'b0;
      scan_valid <= 1'b0;
      scan_code  <= 8'h00;
      scan_ext   <= 1'b0;
      scan_break <= 1'b0;
      frame_err  <= 1'b0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
    end else begin
      slots      <= nxt_slots;
      keyCount   <= nxt_count;
      press      <= (nxt_count != '0);
      keyFull    <= (nxt_count == FULL);
      scan_valid <= is_event;
      frame_err  <= rx_err;

      if (is_event) begin
        scan_code  <= rx_byte;
        scan_ext   <= ext_pend;
        scan_break <= brk_pend;
      end else begin
        scan_code  <= scan_code;
        scan_ext   <= scan_ext;
        scan_break <= scan_break;
      end

      // A damaged frame may have been a prefix, so pending prefixes are dropped.
      if (rx_err) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (rx_valid) begin
        case (rx_byte)
          PS2_EXT: ext_pend <= 1'b1;
          PS2_BRK: brk_pend <= 1'b1;
          PS2_BAT, PS2_ERR0, PS2_ERR1: begin
            ext_pend <= ext_pend;
            brk_pend <= brk_pend;
          end
          default: begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end
        endcase
      end else begin
        ext_pend <= ext_pend;
        brk_pend <= brk_pend;
      end
    end
  end

  // Flatten the slot table onto the output buses.
  always_comb begin
    key_code = '0;
    key_ext  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      key_code[8*i +: 8] = slots[i].code;
      key_ext[i]         = slots[i].ext;
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: table of key sequences with a
// scoreboard of expected events, plus error, timeout and reset sequences.
module tb_ps2_key_tracker;

  localparam int NS = 4;
  localparam int FL = 8;
  localparam int TO = 2000;
  localparam int HB = 30;

  logic        Clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        psClk  = 1'b1;
  logic        psData = 1'b1;
  logic [31:0] key_code;
  logic [3:0]  key_ext;
  logic [2:0]  keyCount;
  logic        press, keyFull, scan_valid, scan_ext, scan_break, frame_err;
  logic [7:0]  scan_code;

  int checks   = 0;
  int failures = 0;
  int err_seen = 0;

  typedef struct {
    logic [7:0]  code;
    logic        ext;
    logic        brk;
    logic [31:0] kc;
    logic [3:0]  ke;
    logic [2:0]  cnt;
  } exp_t;

  typedef struct {
    int          nb;
    logic [23:0] seq;
    logic        ev;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  ps2_key_tracker #(.NUM_SLOTS(NS), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .reset(reset), .psClk(psClk), .psData(psData),
    .key_code(key_code), .key_ext(key_ext), .keyCount(keyCount),
    .press(press), .keyFull(keyFull), .scan_valid(scan_valid),
    .scan_code(scan_code), .scan_ext(scan_ext), .scan_break(scan_break),
    .frame_err(frame_err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mke(input logic [7:0] code, input logic ext, input logic brk,
                               input logic [31:0] kc, input logic [3:0] ke, input logic [2:0] cnt);
    exp_t e;
    e.code = code; e.ext = ext; e.brk = brk; e.kc = kc; e.ke = ke; e.cnt = cnt;
    return e;
  endfunction

  function automatic vec_t mkv(input int nb, input logic [23:0] seq, input logic ev, input exp_t e);
    vec_t v;
    v.nb = nb; v.seq = seq; v.ev = ev; v.e = e;
    return v;
  endfunction

  task automatic check_table(input string tag, input exp_t e);
    check({tag, "_key_code"}, key_code, e.kc);
    check({tag, "_key_ext"},  32'(key_ext), 32'(e.ke));
    check({tag, "_keyCount"}, 32'(keyCount), 32'(e.cnt));
    check({tag, "_press"},    32'(press), 32'(e.cnt != 3'd0));
    check({tag, "_keyFull"},  32'(keyFull), 32'(e.cnt == 3'(NS)));
  endtask

  task automatic check_zero(input string tag);
    check_table(tag, mke(8'h00, 1'b0, 1'b0, 32'h0, 4'h0, 3'd0));
    check({tag, "_scan_valid"}, 32'(scan_valid), 32'd0);
    check({tag, "_scan_code"},  32'(scan_code), 32'd0);
    check({tag, "_frame_err"},  32'(frame_err), 32'd0);
  endtask

  // Scoreboard: every scan_valid pops one expected event, table checked on the same cycle.
  always @(negedge Clk) begin
    if (frame_err) err_seen++;
    if (scan_valid) begin
      if (sb.size() == 0) begin
        check("scan_unexpected", 32'(scan_valid), 32'd0);
      end else begin : pop_blk
        exp_t e;
        e = sb.pop_front();
        check("scan_code",  32'(scan_code),  32'(e.code));
        check("scan_ext",   32'(scan_ext),   32'(e.ext));
        check("scan_break", 32'(scan_break), 32'(e.brk));
        check_table("evt", e);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic send_bit(input logic b);
    psData = b;
    wait_cyc(15);
    psClk = 1'b0;
    wait_cyc(HB);
    psClk = 1'b1;
    wait_cyc(15);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(bad_par ? ^d : ~^d);
    send_bit(bad_stop ? 1'b0 : 1'b1);
    psData = 1'b1;
    wait_cyc(60);
  endtask

  task automatic send_partial();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int err0;
    exp_t e;

    wait_cyc(5);
    check_zero("reset");
    reset = 1'b0;
    wait_cyc(20);

    vecs.push_back(mkv(1, 24'h00001C, 1'b1, mke(8'h1C, 1'b0, 1'b0, 32'h0000001C, 4'h0, 3'd1)));
    vecs.push_back(mkv(2, 24'h00F01C, 1'b1, mke(8'h1C, 1'b0, 1'b1, 32'h00000000, 4'h0, 3'd0)));
    vecs.push_back(mkv(1, 24'h00001C, 1'b1, mke(8'h1C, 1'b0, 1'b0, 32'h0000001C, 4'h0, 3'd1)));
    vecs.push_back(mkv(1, 24'h00001B, 1'b1, mke(8'h1B, 1'b0, 1'b0, 32'h00001C1B, 4'h0, 3'd2)));
    vecs.push_back(mkv(1, 24'h000023, 1'b1, mke(8'h23, 1'b0, 1'b0, 32'h001C1B23, 4'h0, 3'd3)));
    vecs.push_back(mkv(2, 24'h00F01B, 1'b1, mke(8'h1B, 1'b0, 1'b1, 32'h00001C23, 4'h0, 3'd2)));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mkv(1, 24'h00001C, 1'b1, mke(8'h1C, 1'b0, 1'b0, 32'h00001C23, 4'h0, 3'd2)));
    vecs.push_back(mkv(2, 24'h00F01C, 1'b1, mke(8'h1C, 1'b0, 1'b1, 32'h00000023, 4'h0, 3'd1)));
    vecs.push_back(mkv(2, 24'h00F023, 1'b1, mke(8'h23, 1'b0, 1'b1, 32'h00000000, 4'h0, 3'd0)));
    vecs.push_back(mkv(2, 24'h00E075, 1'b1, mke(8'h75, 1'b1, 1'b0, 32'h00000075, 4'h1, 3'd1)));
    vecs.push_back(mkv(1, 24'h000075, 1'b1, mke(8'h75, 1'b0, 1'b0, 32'h00007575, 4'h2, 3'd2)));
    vecs.push_back(mkv(3, 24'hE0F075, 1'b1, mke(8'h75, 1'b1, 1'b1, 32'h00000075, 4'h0, 3'd1)));
    vecs.push_back(mkv(2, 24'h00F075, 1'b1, mke(8'h75, 1'b0, 1'b1, 32'h00000000, 4'h0, 3'd0)));
    vecs.push_back(mkv(1, 24'h0000AA, 1'b0, mke(8'h00, 1'b0, 1'b0, 32'h00000000, 4'h0, 3'd0)));
    vecs.push_back(mkv(1, 24'h00001C, 1'b1, mke(8'h1C, 1'b0, 1'b0, 32'h0000001C, 4'h0, 3'd1)));
    vecs.push_back(mkv(1, 24'h00001B, 1'b1, mke(8'h1B, 1'b0, 1'b0, 32'h00001C1B, 4'h0, 3'd2)));
    vecs.push_back(mkv(1, 24'h000023, 1'b1, mke(8'h23, 1'b0, 1'b0, 32'h001C1B23, 4'h0, 3'd3)));
    vecs.push_back(mkv(1, 24'h00001D, 1'b1, mke(8'h1D, 1'b0, 1'b0, 32'h1C1B231D, 4'h0, 3'd4)));
    vecs.push_back(mkv(1, 24'h000029, 1'b1, mke(8'h29, 1'b0, 1'b0, 32'h1B231D29, 4'h0, 3'd4)));
    vecs.push_back(mkv(2, 24'h00F01C, 1'b1, mke(8'h1C, 1'b0, 1'b1, 32'h1B231D29, 4'h0, 3'd4)));
    vecs.push_back(mkv(2, 24'h00E01B, 1'b1, mke(8'h1B, 1'b1, 1'b0, 32'h231D291B, 4'h1, 3'd4)));

    foreach (vecs[i]) begin
      if (vecs[i].ev) sb.push_back(vecs[i].e);
      for (int k = 0; k < vecs[i].nb; k++)
        send_byte(vecs[i].seq[8*(vecs[i].nb-1-k) +: 8], 1'b0, 1'b0);
      wait_drain();
      check_table($sformatf("vec%0d", i), vecs[i].e);
    end

    // Reset with a full table.
    reset = 1'b1;
    wait_cyc(3);
    check_zero("reset_full");
    reset = 1'b0;
    wait_cyc(20);

    // Damaged frames: error pulse, no event, pending E0 dropped.
    err0 = err_seen;
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'h1C, 1'b1, 1'b0);
    check("err_parity_count", 32'(err_seen), 32'(err0 + 1));
    check_table("err_parity", mke(8'h00, 1'b0, 1'b0, 32'h0, 4'h0, 3'd0));
    send_byte(8'h1C, 1'b0, 1'b1);
    check("err_stop_count", 32'(err_seen), 32'(err0 + 2));
    check_table("err_stop", mke(8'h00, 1'b0, 1'b0, 32'h0, 4'h0, 3'd0));
    e = mke(8'h1C, 1'b0, 1'b0, 32'h0000001C, 4'h0, 3'd1);
    sb.push_back(e);
    send_byte(8'h1C, 1'b0, 1'b0);
    wait_drain();
    check_table("after_err", e);

    // Abandoned frame recovers through the inactivity timeout without an error.
    send_partial();
    wait_cyc(TO + 100);
    e = mke(8'h23, 1'b0, 1'b0, 32'h00001C23, 4'h0, 3'd2);
    sb.push_back(e);
    send_byte(8'h23, 1'b0, 1'b0);
    wait_drain();
    check_table("after_timeout", e);
    check("timeout_no_err", 32'(err_seen), 32'(err0 + 2));

    // Reset in the middle of a frame discards it.
    send_partial();
    reset = 1'b1;
    wait_cyc(3);
    check_zero("reset_midframe");
    reset = 1'b0;
    wait_cyc(20);
    e = mke(8'h1B, 1'b0, 1'b0, 32'h0000001B, 4'h0, 3'd1);
    sb.push_back(e);
    send_byte(8'h1B, 1'b0, 1'b0);
    wait_drain();
    check_table("after_reset", e);

    wait_cyc(50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Parametrised PS/2 keyboard front end and held-key tracker for the game input path. It replaces the fixed 4-key, make-code-whitelisted keyboard block. It filters psClk and deframes 11-bit PS/2 frames with start/parity/stop checking and an inactivity timeout. It decodes E0 (extended) and F0 (break) prefixes and keeps a recency-ordered table of up to NUM_SLOTS held keys for the game logic.

Parameters:
NUM_SLOTS, 4, number of simultaneously tracked held keys (>=2)
FILTER_LEN, 8, consecutive equal Clk samples required before filtered psClk changes level
TIMEOUT_CYCLES, 50000, Clk cycles without a filtered psClk falling edge before an in-progress frame is aborted

Ports:
Clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
psClk  in  1  raw PS/2 clock pin (asynchronous)
psData  in  1  raw PS/2 data pin (asynchronous)
key_code  out  NUM_SLOTS*8  held-key codes; slot i = bits [8i+7:8i]; slot 0 = most recently pressed; empty = 8'h00
key_ext  out  NUM_SLOTS  bit i = slot i is an E0-extended key
keyCount  out  $clog2(NUM_SLOTS+1)  number of occupied slots
press  out  1  keyCount != 0
keyFull  out  1  keyCount == NUM_SLOTS
scan_valid  out  1  one-cycle pulse per decoded key event
scan_code  out  8  event code, valid with scan_valid
scan_ext  out  1  event was E0-prefixed
scan_break  out  1  event was F0-prefixed (release)
frame_err  out  1  one-cycle pulse on parity or stop-bit failure

Behaviour:
- Reset (synchronous, active-high): all outputs 0. Slots empty, frame FSM in IDLE, prefix flags cleared, filter and timeout counters cleared. A reset mid-frame discards the partial frame.
- Input conditioning: psClk and psData each pass a 2-flop synchronizer. Filtered clock changes only after FILTER_LEN consecutive identical synchronized samples. Filtered clock resets to 1.
- Frame FSM, advanced on each filtered-clock falling edge (psData sampled at that edge):
  - IDLE: bit = 0 -> DATA; bit = 1 -> stay in IDLE silently.
  - DATA: 8 bits, LSB first -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: frame is good if stop bit = 1 and data+parity has odd weight. Any failure -> frame_err pulse, frame discarded, prefix flags cleared. Always -> IDLE.
- Timeout: counter clears on every falling edge and in IDLE. Reaching TIMEOUT_CYCLES outside IDLE -> IDLE with no error pulse.
- Decode of a good frame:
  - E0: sets ext_pend.
  - F0: sets brk_pend.
  - 00, FF, AA: ignored; flags unchanged.
  - Any other code: event {code, ext_pend, brk_pend}; both flags cleared.
- Timing: scan_valid is asserted exactly 2 Clk cycles after the cycle the stop bit is sampled. The key table reflects the event on the same cycle scan_valid is high.
- Make event, (code, ext) already present: no table change (typematic repeat).
- Make event, new key: slots shift down one position and the new key is inserted at slot 0. If the table was full, the entry in slot NUM_SLOTS-1 is dropped and keyCount stays at NUM_SLOTS. Otherwise keyCount increments.
- Break event: the matching slot j is removed. Slots j+1..NUM_SLOTS-1 shift up, the last slot is zeroed, keyCount decrements. A break with no matching slot causes no change and no underflow.
- Matching compares both the code and the ext bit, so 0x75 and E0 0x75 are distinct keys.
- No input-side back-pressure. Events are at least 11 PS/2 bit-times apart, so no simultaneous-event handling is required.

Decomposition:
- Package ps2_pkg:
  - frame_state_t enum {IDLE, DATA, PARITY, STOP}
  - key_entry_t packed struct {logic ext; logic [7:0] code}
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_BAT=8'hAA, PS2_ERR0=8'h00, PS2_ERR1=8'hFF
- Sub-module ps2_frame_rx: synchronizers, filter, frame FSM, timeout. Outputs byte_valid, byte, frame_err.
- Top level: prefix decode and key table.

Test Plan:
- Make frame 1C -> scan_valid with code 1C, ext 0, break 0; slot0 = 1C, keyCount 1, press 1. Then F0 1C -> all slots 00, keyCount 0, press 0.
- Makes 1C, 1B, 23, then F0 1B -> slots {23,1B,1C,00} become {23,1C,00,00}, keyCount 2. Then make 1C again x3 -> no change (typematic).
- E0 75 -> slot0 code 75, key_ext[0] 1. Plain 75 -> occupies a second slot. E0 F0 75 -> only the non-extended 75 remains.
- NUM_SLOTS=4, makes 1C, 1B, 23, 1D, 29 -> slots {29,1D,23,1B}, keyFull 1, keyCount 4. Then F0 1C -> no change.
- Frame 1C with even parity -> frame_err pulse, no scan_valid, table unchanged. Bad stop bit behaves the same. A following good frame decodes normally.
- 5 bits of a frame then clock idle for TIMEOUT_CYCLES -> FSM returns to IDLE and the next full frame 23 decodes correctly. Reset asserted mid-frame -> all outputs 0 and the next frame decodes.
